spu_dual_issue_sched: RTL and testbench
=======================================

Name: spu_dual_issue_sched

Overview:
- In-order dual-issue scheduler between decode and the even/odd register-file/functional-unit pipes.
- Each cycle it examines an ordered instruction pair (slot0 older, slot1 younger) and routes each slot to its pipe.
- It detects structural, RAW and WAW hazards against in-flight writes using a per-register latency-countdown scoreboard.
- It stalls decode until every valid slot of the pair has issued.

Parameters:
- NUM_REGS, 128, architectural register count.
- ADDR_W, 7, register address width.
- LAT_W, 4, latency field width (matches latency_even/odd).
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pair_valid  in  1  decode presents a pair; held stable until pair_ready
- pair_ready  out  1  pair fully consumed this cycle (combinational)
- flush  in  1  branch flush; drop the pending pair
- sN_vld  in  1  slot N valid (N=0,1)
- sN_odd  in  1  slot N target pipe: 0=even, 1=odd
- sN_lat  in  LAT_W  slot N writeback latency
- sN_reg_wr  in  1  slot N writes rt
- sN_rt  in  ADDR_W  slot N destination
- sN_ra/sN_rb/sN_rc  in  ADDR_W each  slot N sources
- sN_use  in  3  slot N source-use flags {ra,rb,rc}
- even_issue  out  1  even pipe issues this cycle
- even_sel  out  1  slot driving the even pipe
- odd_issue  out  1  odd pipe issues this cycle
- odd_sel  out  1  slot driving the odd pipe
- stall_cnt  out  PERF_W  saturating count of stall cycles

Behaviour:
- Issue decisions are combinational from the current pair, state and scoreboard. Scoreboard, state and counter update at posedge.
- Reset: every scoreboard count is 0, state PAIR, stall_cnt 0. All issue outputs, sel and pair_ready are 0 while rst=1.
- Scoreboard:
  - cnt[r] is LAT_W bits; register r is busy while cnt[r]!=0.
  - An issuing slot with reg_wr=1 and lat!=0 loads cnt[rt]=lat. reg_wr with lat=0 is treated as no write.
  - Every nonzero cnt not being loaded decrements by 1 each cycle. A load overrides the decrement.
  - A consumer issues no earlier than L+1 cycles after its producer. No forwarding.
- Slot eligibility (single): vld and no used source busy and (reg_wr=0 or rt not busy).
- State PAIR:
  - slot0 issues if eligible.
  - slot1 issues in the same cycle only if all of the following hold:
    - slot0 issues;
    - s1_odd!=s0_odd;
    - slot1 is eligible;
    - no used slot1 source equals s0_rt when s0 writes;
    - not both writing the same rt.
  - Invalid slot0 with valid slot1 is illegal input. Assertion only.
- Transitions:
  - PAIR -> HOLD1 when slot0 issues, s1_vld=1 and slot1 does not issue.
  - HOLD1 evaluates slot1 alone (slot0 ignored) and returns to PAIR when slot1 issues.
  - pair_ready=1 when, this cycle:
    - PAIR: both valid slots issue, or slot0 issues and s1_vld=0;
    - HOLD1: slot1 issues.
- Routing: an issuing slot with odd=0 sets even_issue=1, even_sel=N. odd=1 sets odd_issue=1, odd_sel=N. At most one slot per pipe per cycle.
- flush:
  - Forces no issue and pair_ready=0 that cycle; next state PAIR.
  - Scoreboard keeps counting, since in-flight ops still write back.
  - Decode discards its own pair.
  - flush and rst together: rst wins.
- stall_cnt increments when pair_valid=1, flush=0 and no slot issues; it saturates at all-ones.
- pair_valid=0: no issue; state is held.

Decomposition:
- Package spu_sched_pkg:
  - NUM_REGS, ADDR_W, LAT_W constants;
  - pipe encoding EVEN=0/ODD=1;
  - state enum {PAIR, HOLD1}.
- Sub-module spu_scoreboard:
  - count array;
  - two load ports (one per pipe);
  - eight busy-lookup ports (6 sources + 2 destinations).

Test Plan:
- Independent pair: s0 even rt=3 lat=4, s1 odd rt=1 lat=7, sources r2/r3 idle -> even_issue=1 sel=0, odd_issue=1 sel=1, pair_ready=1. Next cycle cnt[3]=4, cnt[1]=7.
- Same-pipe pair: both even, independent -> cycle t slot0 issues, state HOLD1, pair_ready=0. Cycle t+1 even_sel=1, pair_ready=1. stall_cnt unchanged.
- Intra-pair RAW: s0 even writes r3 lat=4, s1 odd reads ra=r3 -> slot0 at t, slot1 at t+5. stall_cnt +4.
- Cross-pair WAW: pair A writes r5 lat=7 at t, pair B slot0 writes r5 lat=2 -> B issues at t+8, then cnt[5]=2.
- Flush during HOLD1 with cnt[3]=3 -> no issue, pair_ready=0, state PAIR. cnt[3] reads 2 then 1 then 0 on the following cycles.
- Reset mid-operation with cnt[1]=6 -> after release cnt all 0, a dependent reader of r1 issues in the first cycle, stall_cnt=0. A 2^32-cycle forced stall saturates stall_cnt at FFFFFFFF.

Source files
------------

// File: rtl/spu_sched_pkg.sv
// Shared constants and types for the SPU dual-issue scheduler and its scoreboard.
package spu_sched_pkg;
    localparam int NUM_REGS = 128;
    localparam int ADDR_W   = 7;
    localparam int LAT_W    = 4;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    typedef enum logic {PAIR, HOLD1} sched_state_e;
endpackage

// File: rtl/spu_scoreboard.sv
// Per-register writeback countdown; a register is busy while its count is nonzero.
module spu_scoreboard #(
    parameter int NUM_REGS = spu_sched_pkg::NUM_REGS,
    parameter int ADDR_W   = spu_sched_pkg::ADDR_W,
    parameter int LAT_W    = spu_sched_pkg::LAT_W,
    parameter int NUM_Q    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    ld_en,
    input  logic [1:0][ADDR_W-1:0]        ld_reg,
    input  logic [1:0][LAT_W-1:0]         ld_lat,
    input  logic [NUM_Q-1:0][ADDR_W-1:0]  q_reg,
    output logic [NUM_Q-1:0]              q_busy
);
    logic [LAT_W-1:0] cnt [NUM_REGS];

    // A load replaces the countdown; the scheduler never loads the same rt on both pipes.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst)
                cnt[r] <= '0;
            else if (ld_en[0] && ld_reg[0] == ADDR_W'(r))
                cnt[r] <= ld_lat[0];
            else if (ld_en[1] && ld_reg[1] == ADDR_W'(r))
                cnt[r] <= ld_lat[1];
            else if (cnt[r] != '0)
                cnt[r] <= cnt[r] - LAT_W'(1);
        end
    end

    for (genvar q = 0; q < NUM_Q; q++) begin : g_q
        assign q_busy[q] = (cnt[q_reg[q]] != '0);
    end
endmodule

// File: rtl/spu_dual_issue_sched.sv
// In-order dual-issue scheduler: routes an ordered instruction pair to the even/odd pipes,
// holding decode until every valid slot has issued past scoreboard and intra-pair hazards.
module spu_dual_issue_sched #(
    parameter int NUM_REGS = spu_sched_pkg::NUM_REGS,
    parameter int ADDR_W   = spu_sched_pkg::ADDR_W,
    parameter int LAT_W    = spu_sched_pkg::LAT_W,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pair_valid,
    output logic              pair_ready,
    input  logic              flush,
    input  logic              s0_vld,
    input  logic              s0_odd,
    input  logic [LAT_W-1:0]  s0_lat,
    input  logic              s0_reg_wr,
    input  logic [ADDR_W-1:0] s0_rt,
    input  logic [ADDR_W-1:0] s0_ra,
    input  logic [ADDR_W-1:0] s0_rb,
    input  logic [ADDR_W-1:0] s0_rc,
    input  logic [2:0]        s0_use,
    input  logic              s1_vld,
    input  logic              s1_odd,
    input  logic [LAT_W-1:0]  s1_lat,
    input  logic              s1_reg_wr,
    input  logic [ADDR_W-1:0] s1_rt,
    input  logic [ADDR_W-1:0] s1_ra,
    input  logic [ADDR_W-1:0] s1_rb,
    input  logic [ADDR_W-1:0] s1_rc,
    input  logic [2:0]        s1_use,
    output logic              even_issue,
    output logic              even_sel,
    output logic              odd_issue,
    output logic              odd_sel,
    output logic [PERF_W-1:0] stall_cnt
);
    import spu_sched_pkg::*;

    typedef struct packed {
        logic              vld;
        logic              odd;
        logic [LAT_W-1:0]  lat;
        logic              reg_wr;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rc;
        logic [2:0]        src_use;
    } slot_t;

    function automatic logic src_hit(slot_t sl, logic [ADDR_W-1:0] r);
        return (sl.src_use[2] && sl.ra == r) || (sl.src_use[1] && sl.rb == r) ||
               (sl.src_use[0] && sl.rc == r);
    endfunction

    slot_t [1:0]             s;
    logic  [7:0][ADDR_W-1:0] q_reg;
    logic  [7:0]             q_busy;
    logic  [1:0]             wr, elig, iss, ld_en;
    logic  [1:0][ADDR_W-1:0] ld_reg;
    logic  [1:0][LAT_W-1:0]  ld_lat;
    logic                    raw, waw, active;
    sched_state_e            state, state_nxt;

    assign s[0] = '{vld: s0_vld, odd: s0_odd, lat: s0_lat, reg_wr: s0_reg_wr, rt: s0_rt,
                    ra: s0_ra, rb: s0_rb, rc: s0_rc, src_use: s0_use};
    assign s[1] = '{vld: s1_vld, odd: s1_odd, lat: s1_lat, reg_wr: s1_reg_wr, rt: s1_rt,
                    ra: s1_ra, rb: s1_rb, rc: s1_rc, src_use: s1_use};

    // Lookup port order per slot is {rt, ra, rb, rc} so busy bits line up with src_use.
    for (genvar n = 0; n < 2; n++) begin : g_slot
        assign q_reg[4*n+0] = s[n].rc;
        assign q_reg[4*n+1] = s[n].rb;
        assign q_reg[4*n+2] = s[n].ra;
        assign q_reg[4*n+3] = s[n].rt;
        assign wr[n]   = s[n].reg_wr && (s[n].lat != '0);
        assign elig[n] = s[n].vld && ((q_busy[4*n +: 3] & s[n].src_use) == 3'b000) &&
                         !(wr[n] && q_busy[4*n+3]);
    end

    assign raw = wr[0] && src_hit(s[1], s[0].rt);
    assign waw = wr[0] && wr[1] && (s[0].rt == s[1].rt);

    always_comb begin
        active     = !rst && pair_valid && !flush;
        iss        = 2'b00;
        pair_ready = 1'b0;
        state_nxt  = state;
        if (state == PAIR) begin
            iss[0]     = active && elig[0];
            iss[1]     = iss[0] && (s[1].odd != s[0].odd) && elig[1] && !raw && !waw;
            pair_ready = iss[0] && (!s[1].vld || iss[1]);
            if (iss[0] && s[1].vld && !iss[1])
                state_nxt = HOLD1;
        end else begin
            iss[1]     = active && elig[1];
            pair_ready = iss[1];
            if (iss[1])
                state_nxt = PAIR;
        end
        if (flush)
            state_nxt = PAIR;
        even_issue = (iss[0] && s[0].odd == EVEN) || (iss[1] && s[1].odd == EVEN);
        even_sel   = iss[1] && s[1].odd == EVEN;
        odd_issue  = (iss[0] && s[0].odd == ODD) || (iss[1] && s[1].odd == ODD);
        odd_sel    = iss[1] && s[1].odd == ODD;
    end

    assign ld_en[EVEN]  = even_issue && wr[even_sel];
    assign ld_reg[EVEN] = s[even_sel].rt;
    assign ld_lat[EVEN] = s[even_sel].lat;
    assign ld_en[ODD]   = odd_issue && wr[odd_sel];
    assign ld_reg[ODD]  = s[odd_sel].rt;
    assign ld_lat[ODD]  = s[odd_sel].lat;

    spu_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .NUM_Q(8)) u_sb (
        .clk    (clk),
        .rst    (rst),
        .ld_en  (ld_en),
        .ld_reg (ld_reg),
        .ld_lat (ld_lat),
        .q_reg  (q_reg),
        .q_busy (q_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PAIR;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pair_valid && !flush && iss == 2'b00 && stall_cnt != '1)
                stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    a_slot_order: assert property (@(posedge clk) disable iff (rst)
        (pair_valid && !flush && state == PAIR && s1_vld) |-> s0_vld);
endmodule

// File: tb/tb_spu_dual_issue_sched.sv
// Directed bench for spu_dual_issue_sched: single-cycle routing table plus multi-cycle hazard sequences.
module tb_spu_dual_issue_sched;
    import spu_sched_pkg::*;

    typedef struct packed {
        logic       vld, odd;
        logic [3:0] lat;
        logic       wr;
        logic [6:0] rt, ra, rb, rc;
        logic [2:0] su;
    } tslot_t;

    typedef struct {
        string  name;
        logic   pv, fl;
        tslot_t a, b;
        logic   ei, es, oi, os, pr;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, pair_valid = 1'b0, flush = 1'b0;
    logic s0_vld, s0_odd, s0_reg_wr, s1_vld, s1_odd, s1_reg_wr;
    logic [3:0] s0_lat, s1_lat;
    logic [6:0] s0_rt, s0_ra, s0_rb, s0_rc, s1_rt, s1_ra, s1_rb, s1_rc;
    logic [2:0] s0_use, s1_use;
    logic pair_ready, even_issue, even_sel, odd_issue, odd_sel;
    logic [31:0] stall_cnt;
    logic sat_ready, sat_ei, sat_es, sat_oi, sat_os;
    logic [3:0] sat_stall;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    spu_dual_issue_sched dut (
        .clk(clk), .rst(rst), .pair_valid(pair_valid), .pair_ready(pair_ready), .flush(flush),
        .s0_vld(s0_vld), .s0_odd(s0_odd), .s0_lat(s0_lat), .s0_reg_wr(s0_reg_wr), .s0_rt(s0_rt),
        .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rc(s0_rc), .s0_use(s0_use),
        .s1_vld(s1_vld), .s1_odd(s1_odd), .s1_lat(s1_lat), .s1_reg_wr(s1_reg_wr), .s1_rt(s1_rt),
        .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc), .s1_use(s1_use),
        .even_issue(even_issue), .even_sel(even_sel), .odd_issue(odd_issue), .odd_sel(odd_sel),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    spu_dual_issue_sched #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst), .pair_valid(pair_valid), .pair_ready(sat_ready), .flush(flush),
        .s0_vld(s0_vld), .s0_odd(s0_odd), .s0_lat(s0_lat), .s0_reg_wr(s0_reg_wr), .s0_rt(s0_rt),
        .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rc(s0_rc), .s0_use(s0_use),
        .s1_vld(s1_vld), .s1_odd(s1_odd), .s1_lat(s1_lat), .s1_reg_wr(s1_reg_wr), .s1_rt(s1_rt),
        .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc), .s1_use(s1_use),
        .even_issue(sat_ei), .even_sel(sat_es), .odd_issue(sat_oi), .odd_sel(sat_os),
        .stall_cnt(sat_stall)
    );

    function automatic tslot_t sl(logic vld, logic odd, int lat, logic wr, int rt,
                                  int ra, int rb, int rc, logic [2:0] su);
        tslot_t t;
        t.vld = vld; t.odd = odd; t.lat = 4'(lat); t.wr = wr; t.rt = 7'(rt);
        t.ra = 7'(ra); t.rb = 7'(rb); t.rc = 7'(rc); t.su = su;
        return t;
    endfunction

    task automatic drive(input logic pv, input logic fl, input tslot_t a, input tslot_t b);
        pair_valid = pv; flush = fl;
        s0_vld = a.vld; s0_odd = a.odd; s0_lat = a.lat; s0_reg_wr = a.wr; s0_rt = a.rt;
        s0_ra = a.ra; s0_rb = a.rb; s0_rc = a.rc; s0_use = a.su;
        s1_vld = b.vld; s1_odd = b.odd; s1_lat = b.lat; s1_reg_wr = b.wr; s1_rt = b.rt;
        s1_ra = b.ra; s1_rb = b.rb; s1_rc = b.rc; s1_use = b.su;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; pair_valid = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [4:0] outs();
        return {even_issue, even_sel, odd_issue, odd_sel, pair_ready};
    endfunction

    vec_t   vt[12];
    tslot_t nil, w3e, rd3o, ind_o;
    int     early, n, nz;

    initial begin
        nil   = sl(0, EVEN, 0, 0, 0, 0, 0, 0, 3'b000);
        w3e   = sl(1, EVEN, 4, 1, 3, 2, 2, 2, 3'b100);
        rd3o  = sl(1, ODD,  5, 1, 9, 3, 0, 0, 3'b100);
        ind_o = sl(1, ODD,  7, 1, 1, 2, 0, 0, 3'b100);

        vt[0]  = '{"indep",     1, 0, w3e, ind_o, 1, 0, 1, 1, 1};
        vt[1]  = '{"swapped",   1, 0, sl(1, ODD, 4, 1, 3, 2, 0, 0, 3'b100),
                                      sl(1, EVEN, 7, 1, 1, 2, 0, 0, 3'b100), 1, 1, 1, 0, 1};
        vt[2]  = '{"same_pipe", 1, 0, w3e, sl(1, EVEN, 2, 1, 11, 2, 0, 0, 3'b100), 1, 0, 0, 0, 0};
        vt[3]  = '{"s1_inval",  1, 0, w3e, nil, 1, 0, 0, 0, 1};
        vt[4]  = '{"raw_rb",    1, 0, w3e, sl(1, ODD, 2, 0, 9, 0, 3, 0, 3'b010), 1, 0, 0, 0, 0};
        vt[5]  = '{"raw_unused",1, 0, w3e, sl(1, ODD, 2, 0, 9, 2, 3, 3, 3'b100), 1, 0, 1, 1, 1};
        vt[6]  = '{"waw",       1, 0, sl(1, EVEN, 4, 1, 5, 2, 0, 0, 3'b100),
                                      sl(1, ODD, 2, 1, 5, 2, 0, 0, 3'b100), 1, 0, 0, 0, 0};
        vt[7]  = '{"lat0_wr",   1, 0, sl(1, EVEN, 0, 1, 3, 2, 0, 0, 3'b100), rd3o, 1, 0, 1, 1, 1};
        vt[8]  = '{"no_wr",     1, 0, sl(1, EVEN, 4, 0, 3, 2, 0, 0, 3'b100), rd3o, 1, 0, 1, 1, 1};
        vt[9]  = '{"pv_low",    0, 0, w3e, ind_o, 0, 0, 0, 0, 0};
        vt[10] = '{"flush",     1, 1, w3e, ind_o, 0, 0, 0, 0, 0};
        vt[11] = '{"raw_rc",    1, 0, w3e, sl(1, ODD, 2, 0, 9, 0, 0, 3, 3'b001), 1, 0, 0, 0, 0};

        drive(1, 0, w3e, ind_o);
        tick(); tick();
        #1 chk("rst_outs", 32'(outs()), 32'h0);
        chk("rst_stall", stall_cnt, 32'h0);
        chk("rst_state", 32'(dut.state), 32'(PAIR));

        foreach (vt[i]) begin
            reset_dut();
            drive(vt[i].pv, vt[i].fl, vt[i].a, vt[i].b);
            #1 chk(vt[i].name, 32'(outs()),
                   32'({vt[i].ei, vt[i].es, vt[i].oi, vt[i].os, vt[i].pr}));
            rst = 1'b1;
        end

        // Independent pair loads both countdowns.
        reset_dut();
        drive(1, 0, w3e, ind_o);
        #1 chk("ind_outs", 32'(outs()), 32'b10111);
        tick(); pair_valid = 1'b0;
        chk("ind_cnt3", 32'(dut.u_sb.cnt[3]), 32'd4);
        chk("ind_cnt1", 32'(dut.u_sb.cnt[1]), 32'd7);

        // Same-pipe pair splits over two cycles without stalling.
        reset_dut();
        drive(1, 0, sl(1, EVEN, 2, 1, 10, 2, 0, 0, 3'b100), sl(1, EVEN, 2, 1, 11, 2, 0, 0, 3'b100));
        #1 chk("sp_t0", 32'(outs()), 32'b10000);
        tick();
        chk("sp_t1", 32'(outs()), 32'b11001);
        pair_valid = 1'b0;
        tick();
        chk("sp_stall", stall_cnt, 32'd0);

        // Intra-pair RAW: consumer waits latency+1 cycles.
        reset_dut();
        drive(1, 0, w3e, rd3o);
        #1 chk("raw_t0", 32'(outs()), 32'b10000);
        early = 0;
        repeat (4) begin
            tick();
            if (odd_issue || pair_ready) early++;
        end
        chk("raw_early", early, 0);
        tick();
        chk("raw_t5", 32'(outs()), 32'b00111);
        pair_valid = 1'b0;
        tick();
        chk("raw_stall", stall_cnt, 32'd4);

        // Cross-pair WAW on r5.
        reset_dut();
        drive(1, 0, sl(1, EVEN, 7, 1, 5, 2, 0, 0, 3'b100), nil);
        #1 chk("waw_a", 32'(pair_ready), 32'd1);
        tick();
        drive(1, 0, sl(1, ODD, 2, 1, 5, 2, 0, 0, 3'b100), nil);
        n = 0;
        #0;
        while (!odd_issue && n < 20) begin
            tick();
            n++;
        end
        chk("waw_delay", n, 7);
        tick(); pair_valid = 1'b0;
        chk("waw_cnt5", 32'(dut.u_sb.cnt[5]), 32'd2);
        chk("waw_stall", stall_cnt, 32'd7);

        // Flush while holding slot1; countdown keeps running.
        reset_dut();
        drive(1, 0, w3e, rd3o);
        tick(); tick();
        chk("fl_cnt3", 32'(dut.u_sb.cnt[3]), 32'd3);
        flush = 1'b1;
        #1 chk("fl_outs", 32'(outs()), 32'h0);
        tick();
        flush = 1'b0; pair_valid = 1'b0;
        chk("fl_state", 32'(dut.state), 32'(PAIR));
        chk("fl_cnt_a", 32'(dut.u_sb.cnt[3]), 32'd2);
        tick();
        chk("fl_cnt_b", 32'(dut.u_sb.cnt[3]), 32'd1);
        tick();
        chk("fl_cnt_c", 32'(dut.u_sb.cnt[3]), 32'd0);
        drive(1, 0, sl(1, EVEN, 1, 1, 20, 2, 0, 0, 3'b100), nil);
        #1 chk("fl_pair", 32'(outs()), 32'b10001);
        tick(); pair_valid = 1'b0;
        chk("fl_stall", stall_cnt, 32'd1);

        // Reset mid-flight clears the scoreboard and counter.
        reset_dut();
        drive(1, 0, sl(1, EVEN, 6, 1, 1, 2, 0, 0, 3'b100), nil);
        tick(); pair_valid = 1'b0;
        chk("rm_cnt1", 32'(dut.u_sb.cnt[1]), 32'd6);
        reset_dut();
        nz = 0;
        for (int r = 0; r < 128; r++) if (dut.u_sb.cnt[r] != 4'd0) nz++;
        chk("rm_cnt_zero", nz, 0);
        chk("rm_stall", stall_cnt, 32'd0);
        drive(1, 0, sl(1, ODD, 1, 0, 9, 1, 0, 0, 3'b100), nil);
        #1 chk("rm_reader", 32'(outs()), 32'b00101);
        tick(); pair_valid = 1'b0;

        // Stall counter saturation (narrow copy) versus full-width count.
        reset_dut();
        drive(1, 0, nil, nil);
        repeat (20) tick();
        pair_valid = 1'b0;
        chk("sat_wide", stall_cnt, 32'd20);
        chk("sat_narrow", 32'(sat_stall), 32'hF);
        tick();
        chk("sat_hold", 32'(sat_stall), 32'hF);
        chk("sat_idle", 32'({sat_ready, sat_ei, sat_es, sat_oi, sat_os}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
